// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the main-memory port arbiter: sizes, FSM encodings and
// owner bit positions used by the top and the priority selector.
package mem_bus_arbiter_pkg;
  localparam int WORD_SIZE   = 16;
  localparam int BLOCK_WORDS = 4;
  localparam int IDX_W       = $clog2(BLOCK_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Owners are carried one-hot; these are the bit positions.
  localparam int OWN_I   = 0;
  localparam int OWN_D   = 1;
  localparam int OWN_DMA = 2;
  localparam int NUM_OWN = 3;

  typedef logic [NUM_OWN-1:0] owner_t;

  typedef struct packed {
    owner_t owner;
    logic   we;
  } ctx_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Word-level handshake between the arbiter (master) and main memory (slave).
interface mem_bus_arbiter_if #(parameter int WORD_SIZE = 16);
  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_ack;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_bus_arbiter_bus_priority_sel.sv
// Combinational winner pick: D beats I on the CPU side; DMA and CPU alternate
// through lastDma when both are asking.
module bus_priority_sel import mem_bus_arbiter_pkg::*; (
  input  logic   iReq,
  input  logic   dReq,
  input  logic   dmaBr,
  input  logic   lastDma,
  output owner_t grant
);
  owner_t cpuOwn;

  always_comb begin
    cpuOwn = '0;
    if (dReq)      cpuOwn[OWN_D] = 1'b1;
    else if (iReq) cpuOwn[OWN_I] = 1'b1;

    grant = cpuOwn;
    // A lone DMA request always wins; on contention DMA wins only after a CPU block.
    if (dmaBr && (cpuOwn == '0 || !lastDma)) begin
      grant          = '0;
      grant[OWN_DMA] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Owns the shared main-memory port: arbitrates I-fill, D-fill/writeback and DMA,
// then walks one BLOCK_WORDS block word by word over the req/ack handshake.
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
  parameter int WORD_SIZE   = mem_bus_arbiter_pkg::WORD_SIZE,
  parameter int BLOCK_WORDS = mem_bus_arbiter_pkg::BLOCK_WORDS,
  parameter int IDX_W       = mem_bus_arbiter_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 Reset_N,

  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_rvalid,
  output logic                 i_done,

  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_rvalid,
  output logic                 d_done,

  input  logic                 dma_br,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic                 dma_bg,
  output logic                 dma_done,

  output logic [IDX_W-1:0]     word_idx,
  output logic [IDX_W-1:0]     rdata_idx,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 busy,

  mem_bus_arbiter_if.master    mem
);
  logic [1:0]           state;
  ctx_t                 ctx;
  logic [WORD_SIZE-1:0] base;
  logic [IDX_W-1:0]     wordIdx;
  logic                 lastDma;
  owner_t               grant;
  owner_t               rdVld;
  logic                 xfer;
  logic                 done;
  logic                 wordAck;
  logic                 rdAck;
  logic                 lastWord;
  logic [WORD_SIZE-1:0] grantAddr;

  bus_priority_sel uSel (
    .iReq    (i_req),
    .dReq    (d_req),
    .dmaBr   (dma_br),
    .lastDma (lastDma),
    .grant   (grant)
  );

  assign xfer     = (state == ST_XFER);
  assign done     = (state == ST_DONE);
  assign wordAck  = xfer & mem.mem_ack;
  assign rdAck    = wordAck & ~ctx.we;
  assign lastWord = (wordIdx == IDX_W'(BLOCK_WORDS - 1));

  always_comb begin
    grantAddr = i_addr;
    if (grant[OWN_D])   grantAddr = d_addr;
    if (grant[OWN_DMA]) grantAddr = dma_addr;
  end

  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      state   <= ST_IDLE;
      ctx     <= '0;
      base    <= '0;
      wordIdx <= '0;
      lastDma <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != '0) begin
            ctx.owner <= grant;
            ctx.we    <= grant[OWN_D] ? d_we : grant[OWN_DMA];
            base      <= grantAddr & ~WORD_SIZE'(BLOCK_WORDS - 1);
            wordIdx   <= '0;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (mem.mem_ack) begin
            wordIdx <= wordIdx + 1'b1;
            if (lastWord) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          lastDma <= ctx.owner[OWN_DMA];
          wordIdx <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read return is one cycle behind the ack; rdata_idx keeps the word it belongs to.
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      rdVld     <= '0;
      rdata     <= '0;
      rdata_idx <= '0;
    end else begin
      rdVld <= rdAck ? ctx.owner : '0;
      if (rdAck) begin
        rdata     <= mem.mem_rdata;
        rdata_idx <= wordIdx;
      end
    end
  end

  always_comb begin
    mem.mem_wdata = '0;
    if (xfer && ctx.owner[OWN_D])   mem.mem_wdata = d_wdata;
    if (xfer && ctx.owner[OWN_DMA]) mem.mem_wdata = dma_wdata;
  end

  assign mem.mem_req  = xfer;
  assign mem.mem_we   = xfer & ctx.we;
  assign mem.mem_addr = xfer ? (base | WORD_SIZE'(wordIdx)) : '0;

  assign busy     = (state != ST_IDLE);
  assign word_idx = wordIdx;
  assign i_rvalid = rdVld[OWN_I];
  assign d_rvalid = rdVld[OWN_D];
  assign i_done   = done & ctx.owner[OWN_I];
  assign d_done   = done & ctx.owner[OWN_D];
  assign dma_done = done & ctx.owner[OWN_DMA];
  assign dma_bg   = busy & ctx.owner[OWN_DMA];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model predicts every
// output each cycle, and per-scenario literal expectations pin that model.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        Reset_N;
  logic        i_req, d_req, d_we, dma_br;
  logic [15:0] i_addr, d_addr, dma_addr, d_wdata, dma_wdata;
  logic        i_rvalid, i_done, d_rvalid, d_done, dma_bg, dma_done, busy;
  logic [1:0]  word_idx, rdata_idx;
  logic [15:0] rdata;

  mem_bus_arbiter_if #(.WORD_SIZE(16)) memIf ();

  mem_bus_arbiter dut (
    .clk(clk), .Reset_N(Reset_N),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_done(d_done),
    .dma_br(dma_br), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_bg(dma_bg), .dma_done(dma_done),
    .word_idx(word_idx), .rdata_idx(rdata_idx), .rdata(rdata), .busy(busy),
    .mem(memIf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chkOn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Owners present the word currently being transferred.
  always_comb begin
    d_wdata   = 16'hD000 + 16'(word_idx);
    dma_wdata = 16'hA000 + 16'(word_idx);
  end

  // Memory: ack after `lat` cycles of req per word; optional stray ack.
  int          lat = 1;
  bit          strayAck = 0;
  int          wc = 0;
  bit          reqPrev = 0;
  int          reqCnt = 0;
  logic [15:0] addrLog[$];
  logic [15:0] wdataLog[$];
  initial begin memIf.mem_ack = 1'b0; memIf.mem_rdata = '0; end
  always @(negedge clk) begin
    if (!memIf.mem_req)    wc = 0;
    else if (memIf.mem_ack) wc = 0;
    else if (reqPrev)       wc = wc + 1;
    reqPrev = memIf.mem_req;
    memIf.mem_ack   = (memIf.mem_req && wc == lat - 1) || strayAck;
    memIf.mem_rdata = memWord(memIf.mem_addr);
    if (memIf.mem_req) reqCnt++;
    if (memIf.mem_req && memIf.mem_ack) begin
      addrLog.push_back(memIf.mem_addr);
      wdataLog.push_back(memIf.mem_wdata);
    end
  end

  // Observed events: 1=I done, 2=D done, 3=DMA done.
  int          doneLog[$];
  int          iRvCnt = 0, dRvCnt = 0;
  logic [15:0] lastIRdata;
  always @(negedge clk) begin
    if (i_done)   doneLog.push_back(1);
    if (d_done)   doneLog.push_back(2);
    if (dma_done) doneLog.push_back(3);
    if (i_rvalid) begin iRvCnt++; lastIRdata = rdata; end
    if (d_rvalid) dRvCnt++;
  end

  // Transaction model: phase 0 idle, 1 moving words, 2 done; owner 0 none, 1 I, 2 D, 3 DMA.
  int          mPh = 0, mOwn = 0, mIdx = 0, mRv = 0, mRidx = 0;
  logic [15:0] mBase = '0, mRdata = '0;
  bit          mWe = 0, mLast = 0;
  always @(posedge clk) begin
    int          cpu, win;
    logic [15:0] a;
    if (!Reset_N) begin
      mPh = 0; mOwn = 0; mIdx = 0; mRv = 0; mRidx = 0;
      mBase = '0; mRdata = '0; mWe = 0; mLast = 0;
    end else begin
      mRv = 0;
      if (mPh == 1 && memIf.mem_ack && !mWe) begin
        mRv = mOwn; mRdata = memWord(mBase + 16'(mIdx)); mRidx = mIdx;
      end
      case (mPh)
        0: begin
          cpu = d_req ? 2 : (i_req ? 1 : 0);
          if (dma_br && cpu != 0) win = mLast ? cpu : 3;
          else if (dma_br)        win = 3;
          else                    win = cpu;
          if (win != 0) begin
            a     = (win == 1) ? i_addr : (win == 2) ? d_addr : dma_addr;
            mBase = a - (a % 16'd4);
            mWe   = (win == 3) || (win == 2 && d_we);
            mOwn  = win; mIdx = 0; mPh = 1;
          end
        end
        1: if (memIf.mem_ack) begin
          mIdx = mIdx + 1;
          if (mIdx == 4) begin mIdx = 0; mPh = 2; end
        end
        default: begin mLast = (mOwn == 3); mPh = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      chk("busy",     busy,          mPh != 0);
      chk("mem_req",  memIf.mem_req, mPh == 1);
      chk("mem_we",   memIf.mem_we,  mPh == 1 && mWe);
      chk("mem_addr", memIf.mem_addr, (mPh == 1) ? mBase + 16'(mIdx) : 16'h0);
      chk("word_idx", word_idx,      mIdx);
      chk("dma_bg",   dma_bg,        mPh != 0 && mOwn == 3);
      chk("i_done",   i_done,        mPh == 2 && mOwn == 1);
      chk("d_done",   d_done,        mPh == 2 && mOwn == 2);
      chk("dma_done", dma_done,      mPh == 2 && mOwn == 3);
      chk("i_rvalid", i_rvalid,      mRv == 1);
      chk("d_rvalid", d_rvalid,      mRv == 2);
      if (mRv != 0) begin
        chk("rdata",     rdata,     mRdata);
        chk("rdata_idx", rdata_idx, mRidx);
      end
      if (mPh == 1 && mWe)
        chk("mem_wdata", memIf.mem_wdata, ((mOwn == 2) ? 16'hD000 : 16'hA000) + 16'(mIdx));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic waitDone(input string name, input int which, input int maxCyc);
    bit seen = 0;
    for (int k = 0; k < maxCyc; k++) begin
      if ((which == 1 && i_done) || (which == 2 && d_done) || (which == 3 && dma_done)) begin
        seen = 1; break;
      end
      tick();
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic waitIdx(input string name, input logic [1:0] idx, input int maxCyc);
    bit seen = 0;
    for (int k = 0; k < maxCyc; k++) begin
      if (memIf.mem_req && word_idx == idx) begin seen = 1; break; end
      tick();
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    int cyc, gap;
    logic [15:0] expAddr [4];
    Reset_N = 0; i_req = 0; d_req = 0; d_we = 0; dma_br = 0;
    i_addr = '0; d_addr = '0; dma_addr = '0;
    tick(); chkOn = 1;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", memIf.mem_req, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_word_idx", word_idx, 2'd0);
    Reset_N = 1; tick();

    // I fill alone, ack every cycle
    addrLog.delete(); iRvCnt = 0;
    i_req = 1; i_addr = 16'h0013; tick(); i_req = 0;
    waitDone("t1_i_done", 1, 20);
    expAddr = '{16'h10, 16'h11, 16'h12, 16'h13};
    chk("t1_nwords", addrLog.size(), 4);
    for (int k = 0; k < 4 && k < addrLog.size(); k++) chk("t1_addr", addrLog[k], expAddr[k]);
    tick();
    chk("t1_rvalids", iRvCnt, 4);
    chk("t1_last_rdata", lastIRdata, 16'hC3B6);

    // D writeback and I fill requested together
    addrLog.delete(); wdataLog.delete();
    d_req = 1; d_we = 1; d_addr = 16'h0020; i_req = 1; i_addr = 16'h0041;
    tick(); d_req = 0;
    waitDone("t2_d_done", 2, 20);
    gap = 0;
    for (int k = 0; k < 10 && !memIf.mem_req; k++) begin tick(); gap++; end
    chk("t2_gap", gap, 2);
    chk("t2_i_start_addr", memIf.mem_addr, 16'h0040);
    i_req = 0;
    for (int k = 0; k < 4 && k < addrLog.size(); k++) begin
      chk("t2_d_addr", addrLog[k], 16'h0020 + 16'(k));
      chk("t2_d_wdata", wdataLog[k], 16'hD000 + 16'(k));
    end
    waitDone("t2_i_done", 1, 20);
    tick();

    // DMA and I contend continuously: grants alternate starting with DMA
    doneLog.delete();
    dma_br = 1; dma_addr = 16'h0104; i_req = 1; i_addr = 16'h0203;
    for (int k = 0; k < 200 && doneLog.size() < 4; k++) tick();
    dma_br = 0; i_req = 0;
    chk("t3_nblocks", doneLog.size(), 4);
    if (doneLog.size() == 4) begin
      chk("t3_order0", doneLog[0], 3);
      chk("t3_order1", doneLog[1], 1);
      chk("t3_order2", doneLog[2], 3);
      chk("t3_order3", doneLog[3], 1);
    end
    tick(); tick();

    // 3-cycle memory latency
    lat = 3; reqCnt = 0;
    i_req = 1; i_addr = 16'h0030; tick(); i_req = 0;
    cyc = 1;
    for (int k = 0; k < 40 && !i_done; k++) begin tick(); cyc++; end
    chk("t4_block_cycles", cyc, 13);
    chk("t4_req_cycles", reqCnt, 12);
    tick(); tick();

    // Reset in the middle of a D fill
    lat = 2; doneLog.delete();
    d_req = 1; d_we = 0; d_addr = 16'h0052; tick(); d_req = 0;
    waitIdx("t5_reach_w1", 2'd1, 20);
    Reset_N = 0; tick();
    chk("t5_busy", busy, 1'b0);
    chk("t5_mem_req", memIf.mem_req, 1'b0);
    chk("t5_word_idx", word_idx, 2'd0);
    chk("t5_d_rvalid", d_rvalid, 1'b0);
    chk("t5_rdata", rdata, 16'h0);
    Reset_N = 1; tick(); tick(); tick();
    chk("t5_no_done", doneLog.size(), 0);
    addrLog.delete();
    d_req = 1; d_addr = 16'h0054; tick(); d_req = 0;
    waitDone("t5_d_done", 2, 30);
    chk("t5_restart_nwords", addrLog.size(), 4);
    if (addrLog.size() > 0) chk("t5_restart_addr", addrLog[0], 16'h0054);
    tick(); tick();

    // Stray ack in IDLE, then I request dropped mid-block
    iRvCnt = 0; dRvCnt = 0; lat = 1;
    strayAck = 1; tick(); tick(); tick(); strayAck = 0;
    chk("t6_stray_rvalid", iRvCnt + dRvCnt, 0);
    lat = 2;
    i_req = 1; i_addr = 16'h0060; tick();
    waitIdx("t6_reach_w2", 2'd2, 20);
    i_req = 0;
    waitDone("t6_i_done", 1, 30);
    tick();
    chk("t6_rvalids", iRvCnt, 4);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
